// File: rtl/spi_ram_burst.sv
// spi_ram_burst: command-decoded word memory sitting between an SPI slave
// receive path and its transmit serialiser. Supports SET_WA / WRITE / SET_RA /
// READ commands, a tx_valid/tx_ready output handshake, sticky out-of-range
// and read-overrun flags.
// Optional macro SPI_RAM_BURST_AUTOINC_EN: when defined, the write and read
// addresses advance after every WRITE and every accepted READ. When it is
// undefined, the addresses are fixed and change only through SET_WA / SET_RA.
module spi_ram_burst #(
   parameter int MEM_WIDTH = 8,
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [MEM_WIDTH+1:0] din,
   input  logic                 rx_valid,
   input  logic                 tx_ready,
   output logic [MEM_WIDTH-1:0] dout,
   output logic                 tx_valid,
   output logic                 addr_err,
   output logic                 overrun
);

   typedef enum logic {
      IDLE,
      TX_HOLD
   } state_t;

   typedef enum logic [1:0] {
      OP_SET_WA = 2'b00,
      OP_WRITE  = 2'b01,
      OP_SET_RA = 2'b10,
      OP_READ   = 2'b11
   } op_t;

   // Depth held one bit wider than an address so MEM_DEPTH == 2**ADDR_SIZE fits.
   localparam logic [ADDR_SIZE:0] DEPTH_EXT = (ADDR_SIZE+1)'(MEM_DEPTH);

   logic [MEM_WIDTH-1:0] r_mem [MEM_DEPTH];
   state_t               r_state;
   state_t               w_state_nxt;
   logic [ADDR_SIZE-1:0] r_addr_wr;
   logic [ADDR_SIZE-1:0] r_addr_rd;
   logic [MEM_WIDTH-1:0] r_dout;
   logic                 r_addr_err;
   logic                 r_overrun;

   op_t                  w_op;
   logic [MEM_WIDTH-1:0] w_payload;
   logic [ADDR_SIZE-1:0] w_payload_addr;
   logic                 w_set_wa;
   logic                 w_write;
   logic                 w_set_ra;
   logic                 w_rd_accept;
   logic                 w_rd_drop;
   logic                 w_wr_in_range;
   logic                 w_rd_in_range;
   logic [MEM_WIDTH-1:0] w_rd_data;
   logic [ADDR_SIZE-1:0] w_addr_wr_next;
   logic [ADDR_SIZE-1:0] w_addr_rd_next;

   assign w_op           = op_t'(din[MEM_WIDTH+1:MEM_WIDTH]);
   assign w_payload      = din[MEM_WIDTH-1:0];
   assign w_payload_addr = din[ADDR_SIZE-1:0];

   assign w_wr_in_range  = ({1'b0, r_addr_wr} < DEPTH_EXT);
   assign w_rd_in_range  = ({1'b0, r_addr_rd} < DEPTH_EXT);
   assign w_rd_data      = w_rd_in_range ? r_mem[r_addr_rd] : '0;

`ifdef SPI_RAM_BURST_AUTOINC_EN
   localparam logic [ADDR_SIZE:0] LAST_EXT = (ADDR_SIZE+1)'(MEM_DEPTH - 1);

   // Advance by one; the last legal word and any out-of-range address go to 0.
   function automatic logic [ADDR_SIZE-1:0] f_advance(input logic [ADDR_SIZE-1:0] a);
      if ({1'b0, a} >= LAST_EXT) begin
         return '0;
      end
      return a + ADDR_SIZE'(1);
   endfunction

   assign w_addr_wr_next = f_advance(r_addr_wr);
   assign w_addr_rd_next = f_advance(r_addr_rd);
`else
   assign w_addr_wr_next = r_addr_wr;
   assign w_addr_rd_next = r_addr_rd;
`endif

   // State register for the output handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Command decode, read acceptance and handshake next-state.
   always_comb begin
      w_state_nxt = r_state;
      w_set_wa    = 1'b0;
      w_write     = 1'b0;
      w_set_ra    = 1'b0;
      w_rd_accept = 1'b0;
      w_rd_drop   = 1'b0;
      if (rx_valid) begin
         case (w_op)
            OP_SET_WA: w_set_wa = 1'b1;
            OP_WRITE:  w_write  = 1'b1;
            OP_SET_RA: w_set_ra = 1'b1;
            OP_READ: begin
               // A read is taken when nothing is held or the held word leaves this edge.
               if ((r_state == IDLE) || tx_ready) begin
                  w_rd_accept = 1'b1;
               end else begin
                  w_rd_drop = 1'b1;
               end
            end
         endcase
      end
      case (r_state)
         IDLE: begin
            if (w_rd_accept) begin
               w_state_nxt = TX_HOLD;
            end
         end
         TX_HOLD: begin
            if (tx_ready && !w_rd_accept) begin
               w_state_nxt = IDLE;
            end
         end
      endcase
   end

   // Memory array write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (!rst && w_write && w_wr_in_range) begin
         r_mem[r_addr_wr] <= w_payload;
      end
   end

   // Address pointers, read data register and sticky flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr_wr  <= '0;
         r_addr_rd  <= '0;
         r_dout     <= '0;
         r_addr_err <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         if (w_set_wa) begin
            r_addr_wr <= w_payload_addr;
         end
         if (w_write) begin
            r_addr_wr <= w_addr_wr_next;
            if (!w_wr_in_range) begin
               r_addr_err <= 1'b1;
            end
         end
         if (w_set_ra) begin
            r_addr_rd <= w_payload_addr;
         end
         if (w_rd_accept) begin
            r_dout    <= w_rd_data;
            r_addr_rd <= w_addr_rd_next;
            if (!w_rd_in_range) begin
               r_addr_err <= 1'b1;
            end
         end
         if (w_rd_drop) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign dout     = r_dout;
   assign tx_valid = (r_state == TX_HOLD);
   assign addr_err = r_addr_err;
   assign overrun  = r_overrun;

endmodule

// File: tb/tb_spi_ram_burst.sv
// tb_spi_ram_burst: drives two spi_ram_burst instances (depth 256 and 200)
// with the same command stream and compares both against a transaction-level
// model every cycle, plus literal expectations for the directed scenarios.
module tb_spi_ram_burst;

   localparam int W  = 8;
   localparam int NI = 2;
`ifdef SPI_RAM_BURST_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         rx_valid = 1'b0;
   logic         tx_ready = 1'b0;
   logic [W+1:0] din = '0;
   logic [W-1:0] dout [NI];
   logic         tx_valid [NI];
   logic         addr_err [NI];
   logic         overrun [NI];

   always #5 clk = ~clk;

   spi_ram_burst #(.MEM_WIDTH(8), .MEM_DEPTH(256), .ADDR_SIZE(8)) u_dut0 (
      .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid), .tx_ready(tx_ready),
      .dout(dout[0]), .tx_valid(tx_valid[0]), .addr_err(addr_err[0]), .overrun(overrun[0])
   );

   spi_ram_burst #(.MEM_WIDTH(8), .MEM_DEPTH(200), .ADDR_SIZE(8)) u_dut1 (
      .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid), .tx_ready(tx_ready),
      .dout(dout[1]), .tx_valid(tx_valid[1]), .addr_err(addr_err[1]), .overrun(overrun[1])
   );

   // ---------------- reference model ----------------
   int unsigned depth [NI] = '{256, 200};
   int unsigned m_mem [NI][256];
   int unsigned m_wa [NI];
   int unsigned m_ra [NI];
   int unsigned m_dout [NI];
   bit          m_hold [NI];
   bit          m_aerr [NI];
   bit          m_ovr [NI];
   bit          m_live = 1'b0;
   int          checks = 0;
   int          errors = 0;

   function automatic int unsigned adv(input int unsigned a, input int unsigned d);
      if (!AUTOINC) return a;
      return (a + 1 < d) ? a + 1 : 0;
   endfunction

   task automatic chk(input string name, input int k, input int unsigned act, input int unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s[%0d] got %0h expected %0h at %0t", name, k, act, exp, $time);
      end
   endtask

   int unsigned mop, mpl;
   bit          macc;
   always @(posedge clk) begin
      mop = int'(din[W+1:W]);
      mpl = int'(din[W-1:0]);
      for (int k = 0; k < NI; k++) begin
         if (rst) begin
            m_wa[k] = 0; m_ra[k] = 0; m_dout[k] = 0;
            m_hold[k] = 0; m_aerr[k] = 0; m_ovr[k] = 0;
         end else if (m_live) begin
            macc = 1'b0;
            if (rx_valid) begin
               case (mop)
                  0: m_wa[k] = mpl;
                  1: begin
                     if (m_wa[k] < depth[k]) m_mem[k][m_wa[k]] = mpl;
                     else m_aerr[k] = 1'b1;
                     m_wa[k] = adv(m_wa[k], depth[k]);
                  end
                  2: m_ra[k] = mpl;
                  default: begin
                     if (!m_hold[k] || tx_ready) begin
                        macc = 1'b1;
                        if (m_ra[k] < depth[k]) m_dout[k] = m_mem[k][m_ra[k]];
                        else begin
                           m_dout[k] = 0;
                           m_aerr[k] = 1'b1;
                        end
                        m_hold[k] = 1'b1;
                        m_ra[k] = adv(m_ra[k], depth[k]);
                     end else begin
                        m_ovr[k] = 1'b1;
                     end
                  end
               endcase
            end
            if (!macc && m_hold[k] && tx_ready) m_hold[k] = 1'b0;
         end
      end
      if (rst) m_live = 1'b1;
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (m_live) begin
         for (int k = 0; k < NI; k++) begin
            chk("dout", k, int'(dout[k]), m_dout[k]);
            chk("tx_valid", k, int'(tx_valid[k]), int'(m_hold[k]));
            chk("addr_err", k, int'(addr_err[k]), int'(m_aerr[k]));
            chk("overrun", k, int'(overrun[k]), int'(m_ovr[k]));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input logic r, input logic v, input logic [1:0] op,
                      input logic [7:0] pl, input logic rdy);
      rst = r; rx_valid = v; din = {op, pl}; tx_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic cmd(input logic [1:0] op, input logic [7:0] pl);
      cyc(1'b0, 1'b1, op, pl, 1'b0);
   endtask

   task automatic idle(input logic rdy);
      cyc(1'b0, 1'b0, 2'b00, 8'h00, rdy);
   endtask

   logic [7:0] exp8;
   logic [7:0] pl_r;
   logic [7:0] edge_vals [4] = '{8'h00, 8'hC7, 8'hC8, 8'hFF};

   initial begin
      // Reset held two cycles while a READ is presented.
      cyc(1'b1, 1'b1, 2'b11, 8'h55, 1'b0);
      cyc(1'b1, 1'b1, 2'b11, 8'h55, 1'b0);
      idle(1'b0);
      for (int k = 0; k < NI; k++) begin
         chk("rst_dout", k, int'(dout[k]), 0);
         chk("rst_tx_valid", k, int'(tx_valid[k]), 0);
         chk("rst_addr_err", k, int'(addr_err[k]), 0);
         chk("rst_overrun", k, int'(overrun[k]), 0);
      end

      // Preload every word with addr ^ 0x5A, then reset (memory survives).
      for (int a = 0; a < 256; a++) begin
         cmd(2'b00, 8'(a));
         cmd(2'b01, 8'(a) ^ 8'h5A);
      end
      cyc(1'b1, 1'b0, 2'b00, 8'h00, 1'b0);
      idle(1'b0);

      // Burst write / read at 0x10.
      cmd(2'b00, 8'h10);
      cmd(2'b01, 8'hA1);
      cmd(2'b01, 8'hA2);
      cmd(2'b01, 8'hA3);
      cmd(2'b10, 8'h10);
      for (int i = 0; i < 3; i++) begin
         cmd(2'b11, 8'h00);
         exp8 = AUTOINC ? 8'(8'hA1 + i) : 8'hA3;
         chk("burst_dout", 0, int'(dout[0]), int'(exp8));
         chk("burst_tx_valid", 0, int'(tx_valid[0]), 1);
         idle(1'b1);
      end
      chk("burst_released", 0, int'(tx_valid[0]), 0);

      // Wrap at the top of the 256-word array.
      cmd(2'b00, 8'hFF);
      cmd(2'b01, 8'h11);
      cmd(2'b01, 8'h22);
      cmd(2'b10, 8'hFF);
      for (int i = 0; i < 2; i++) begin
         cmd(2'b11, 8'h00);
         exp8 = (AUTOINC && i == 0) ? 8'h11 : 8'h22;
         chk("wrap_dout", 0, int'(dout[0]), int'(exp8));
         idle(1'b1);
      end

      // Out-of-range read on the 200-word instance.
      cyc(1'b1, 1'b0, 2'b00, 8'h00, 1'b0);
      cmd(2'b10, 8'hC8);
      cmd(2'b11, 8'h00);
      chk("oor_dout", 1, int'(dout[1]), 0);
      chk("oor_tx_valid", 1, int'(tx_valid[1]), 1);
      chk("oor_addr_err", 1, int'(addr_err[1]), 1);
      chk("inrange_dout", 0, int'(dout[0]), int'(8'hC8 ^ 8'h5A));
      chk("inrange_addr_err", 0, int'(addr_err[0]), 0);
      idle(1'b1);
      cmd(2'b00, 8'hC8);
      cmd(2'b01, 8'hEE);
      cmd(2'b10, 8'hC7);
      cmd(2'b11, 8'h00);
      chk("oor_write_c7", 1, int'(dout[1]), int'(8'hC7 ^ 8'h5A));
      idle(1'b1);

      // Overrun: second READ while the first is still held.
      cyc(1'b1, 1'b0, 2'b00, 8'h00, 1'b0);
      cmd(2'b10, 8'h20);
      cmd(2'b11, 8'h00);
      cmd(2'b11, 8'h00);
      for (int i = 0; i < 3; i++) idle(1'b0);
      chk("ovr_dout", 0, int'(dout[0]), int'(8'h20 ^ 8'h5A));
      chk("ovr_tx_valid", 0, int'(tx_valid[0]), 1);
      chk("ovr_flag", 0, int'(overrun[0]), 1);
      idle(1'b1);
      cmd(2'b11, 8'h00);
      exp8 = AUTOINC ? (8'h21 ^ 8'h5A) : (8'h20 ^ 8'h5A);
      chk("ovr_next_read", 0, int'(dout[0]), int'(exp8));
      idle(1'b1);

      // Back-to-back reads on the tx_ready cycle, then reset mid-hold.
      cmd(2'b10, 8'h30);
      cmd(2'b11, 8'h00);
      for (int i = 1; i <= 4; i++) begin
         cyc(1'b0, 1'b1, 2'b11, 8'h00, 1'b1);
         exp8 = AUTOINC ? (8'(8'h30 + i) ^ 8'h5A) : (8'h30 ^ 8'h5A);
         chk("b2b_dout", 0, int'(dout[0]), int'(exp8));
         chk("b2b_tx_valid", 0, int'(tx_valid[0]), 1);
      end
      cyc(1'b1, 1'b0, 2'b00, 8'h00, 1'b0);
      chk("rst_hold_tx_valid", 0, int'(tx_valid[0]), 0);
      chk("rst_hold_dout", 0, int'(dout[0]), 0);

      // Randomised traffic, boundary-biased payloads, rare resets.
      for (int n = 0; n < 3000; n++) begin
         pl_r = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)]
                                            : 8'($urandom_range(0, 255));
         cyc(($urandom_range(0, 299) == 0),
             ($urandom_range(0, 3) != 0),
             2'($urandom_range(0, 3)),
             pl_r,
             ($urandom_range(0, 2) != 0));
      end
      idle(1'b1);
      idle(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_ram_burst.md
Name: spi_ram_burst

Overview:
Parametrised successor to the SPI slave memory. It decodes 2-bit-opcode command words from the SPI receive path and stores them in an internal MEM_DEPTH x MEM_WIDTH array. It adds address auto-increment for burst transfers, a tx_valid/tx_ready output handshake, out-of-range address detection and read-overrun detection. It sits between the SPI slave shift logic (rx side) and the SPI slave transmit serialiser (tx side).

Parameters:
MEM_WIDTH, 8, data word width; also the command payload width.
MEM_DEPTH, 256, number of words; legal range 2..2**ADDR_SIZE.
ADDR_SIZE, 8, address width; must be <= MEM_WIDTH. The address is taken from din[ADDR_SIZE-1:0].

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
din  in  MEM_WIDTH+2  command word: opcode din[MEM_WIDTH+1:MEM_WIDTH], payload din[MEM_WIDTH-1:0]
rx_valid  in  1  din valid this cycle; one command per high cycle
tx_ready  in  1  downstream accepts dout this cycle
dout  out  MEM_WIDTH  read data
tx_valid  out  1  dout valid; held until accepted
addr_err  out  1  sticky: access to an address >= MEM_DEPTH occurred
overrun  out  1  sticky: a read command was dropped

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset (rst high at a rising edge):
  - dout=0, tx_valid=0, addr_err=0, overrun=0, addr_wr=0, addr_rd=0, state=IDLE.
  - Memory contents are not reset.
  - rst has priority over all commands, including a pending tx handshake; a held word is discarded.
- Opcodes are sampled only when rx_valid=1 at the rising edge:
  - 00 SET_WA: addr_wr <= payload[ADDR_SIZE-1:0].
  - 01 WRITE: mem[addr_wr] <= payload; addr_wr advances (see Optional Feature).
  - 10 SET_RA: addr_rd <= payload[ADDR_SIZE-1:0].
  - 11 READ: fetch mem[addr_rd]; addr_rd advances (see Optional Feature).
- States: IDLE, TX_HOLD.
  - IDLE + accepted READ: dout <= mem[addr_rd], tx_valid <= 1, go to TX_HOLD. Latency: dout/tx_valid valid the cycle after the READ edge.
  - TX_HOLD: dout and tx_valid stay stable. At an edge with tx_ready=1, tx_valid <= 0 and state goes to IDLE.
  - TX_HOLD + READ in the same cycle as tx_ready=1: the handshake completes and the new read is accepted. dout is reloaded, tx_valid stays 1, state stays TX_HOLD (back-to-back reads, no bubble).
  - TX_HOLD + READ with tx_ready=0: the read is dropped, addr_rd is unchanged, overrun <= 1.
  - SET_WA, WRITE and SET_RA are processed in either state and never stall.
- Range checks:
  - WRITE with addr_wr >= MEM_DEPTH: memory unchanged, addr_err <= 1, address still advances.
  - READ with addr_rd >= MEM_DEPTH: dout <= 0, tx_valid asserted normally, addr_err <= 1.
- Advance rule: address increments by 1 and wraps MEM_DEPTH-1 -> 0. Any address >= MEM_DEPTH advances to 0.
- Read-after-write: mem is read at the edge after the write edge, so it returns the newly written data. No same-cycle case exists.
- tx_ready while tx_valid=0 is ignored.
- Sticky flags clear only on rst.

Optional Feature:
- Macro SPI_RAM_BURST_AUTOINC_EN.
- Defined: addr_wr and addr_rd advance after every WRITE and every accepted READ, per the advance rule.
- Undefined: neither address ever advances; they change only via SET_WA / SET_RA (fixed-address, legacy-compatible behaviour). Range checks and the handshake are unchanged.

Test Plan:
- rst=1 for 2 cycles with rx_valid=1, din=11_xx -> dout=0, tx_valid=0, addr_err=0, overrun=0 after release.
- SET_WA 0x10; WRITE 0xA1, 0xA2, 0xA3; SET_RA 0x10; 3 READs, each with tx_ready=1 in the following cycle -> dout 0xA1, 0xA2, 0xA3 (AUTOINC_EN defined). Undefined: dout 0xA3 three times, with mem[0x10]=0xA3.
- MEM_DEPTH=256: SET_WA 0xFF; WRITE 0x11, 0x22; read 0xFF then 0x00 -> 0x11, 0x22 (wrap).
- MEM_DEPTH=200: SET_RA 0xC8; READ -> dout=0, tx_valid=1, addr_err=1. WRITE at 0xC8 -> no array word changes.
- READ with tx_ready held 0 for 5 cycles, second READ issued in cycle 2 -> dout held stable, overrun=1, addr_rd advanced by 1 only.
- READ accepted in TX_HOLD on the tx_ready=1 cycle, repeated 4 times -> tx_valid continuously 1, four distinct words delivered. Then rst asserted mid-hold -> tx_valid=0 next cycle.
